// File: rtl/ram_dport_arbiter.sv
// Shares the single RAM data port between the core LSU (req 0) and the loader/debug port (req 1).
// Latency: grant in T, RAM driven in T+1, read data + rvalid registered in T+2; one access per 2 cycles.
// Backpressure: reqN is held until gntN; no grant is issued while an access is in flight.
// Option: define RAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins, 1 may starve).
module ram_dport_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_wEn,
  output logic [ADDR_WIDTH-1:0] ram_d_address,
  output logic [DATA_WIDTH-1:0] ram_d_write_data,
  input  logic [DATA_WIDTH-1:0] ram_d_read_data
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t state, state_nxt;
  logic   lat_we;   // latched write enable of the access in flight
  logic   owner;    // requester that owns the access in flight
  logic   pick1;    // arbitration result: requester 1 wins if it asks

`ifdef RAM_ARB_FIXED_PRIO_EN
  // Requester 1 only wins when requester 0 is not asking.
  always_comb begin
    pick1 = req1 && !req0;
  end
`else
  logic last_grant; // requester granted most recently

  // Round-robin: on contention the requester that did not win last time goes.
  always_comb begin
    pick1 = req1 && (!req0 || !last_grant);
  end

  // Remember who won the latest grant; reset favours requester 0 first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last_grant <= gnt1;
    end
  end
`endif

  // Next state and combinational grants; grants are gated by reset so they read low during reset.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      IDLE: begin
        if (reset && (req0 || req1)) begin
          gnt1      = pick1;
          gnt0      = !pick1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write strobe is combinational from state so an asynchronous reset kills it at once.
  always_comb begin
    ram_wEn = (state == ACCESS) && lat_we;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // One-entry request buffer; it doubles as the RAM address/data drive, which holds between accesses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ram_d_address    <= '0;
      ram_d_write_data <= '0;
      lat_we           <= 1'b0;
      owner            <= 1'b0;
    end else if (gnt0 || gnt1) begin
      ram_d_address    <= gnt1 ? addr1  : addr0;
      ram_d_write_data <= gnt1 ? wdata1 : wdata0;
      lat_we           <= gnt1 ? we1    : we0;
      owner            <= gnt1;
    end
  end

  // Registered read response: capture RAM data at the end of a read access, pulse rvalid for one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (state == ACCESS && !lat_we) begin
        if (owner) begin
          rvalid1 <= 1'b1;
          rdata1  <= ram_d_read_data;
        end else begin
          rvalid0 <= 1'b1;
          rdata0  <= ram_d_read_data;
        end
      end
    end
  end

endmodule

// File: doc/ram_dport_arbiter.md
Name: ram_dport_arbiter

Overview:
- Two-requester arbiter that shares the single data port of the `ram` block: write is synchronous on `clock`, read is combinational.
- Requester 0 is the core load/store unit. Requester 1 is the program loader/debug port, which preloads instruction memory in place of file loading.
- Each access is latched into a one-entry request buffer, driven to the RAM for exactly one cycle, and read data is returned through a registered response.
- Sits between the core/loader and `ram`. The instruction port is not touched.

Parameters:
- DATA_WIDTH, 32, word width of the RAM data port.
- ADDR_WIDTH, 16, word address width of the RAM data port.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 access request; held until gnt0.
- we0  in  1  requester 0 write enable (1 = write, 0 = read).
- addr0  in  ADDR_WIDTH  requester 0 word address.
- wdata0  in  DATA_WIDTH  requester 0 write data.
- gnt0  out  1  request 0 accepted this cycle.
- rvalid0  out  1  one-cycle pulse; rdata0 valid (reads only).
- rdata0  out  DATA_WIDTH  requester 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as requester 0, for requester 1.
- ram_wEn  out  1  to ram wEn.
- ram_d_address  out  ADDR_WIDTH  to ram d_address.
- ram_d_write_data  out  DATA_WIDTH  to ram d_write_data.
- ram_d_read_data  in  DATA_WIDTH  from ram d_read_data.

Behaviour:
- Reset values (reset low, asynchronous):
  - state = IDLE; gnt0/gnt1 = 0; rvalid0/rvalid1 = 0.
  - rdata0/rdata1 = 0; ram_wEn = 0; ram_d_address = 0; ram_d_write_data = 0.
  - last_grant = 1, so requester 0 wins the first contest.
- State machine, two states:
  - IDLE:
    - gnt is combinational from req and the arbitration choice. At most one gnt is high.
    - On the edge where gntN = 1: latch addrN/weN/wdataN and owner = N; go to ACCESS.
    - No request: stay in IDLE.
  - ACCESS:
    - gnt0 = gnt1 = 0.
    - ram_d_address = latched address; ram_d_write_data = latched data; ram_wEn = latched we.
    - At the next edge: the RAM performs the write. For a read, ram_d_read_data is captured into rdata[owner] and rvalid[owner] is set.
    - Then go to IDLE.
- Outside ACCESS: ram_wEn = 0; address and data outputs hold their last values.
- Latency: request granted in cycle T; RAM driven in cycle T+1; rvalid and rdata present in cycle T+2.
  - Writes produce no rvalid. The write is committed at the end of T+1.
- Throughput: at most one access every 2 cycles.
- rvalidN is high for exactly one cycle. rdataN holds its value until the next read completes for that requester.
- Requests arriving in ACCESS wait; gnt is never issued while in ACCESS.
- A new grant may be issued in the same cycle that rvalid is high.
- Arbitration, both requesting in IDLE:
  - Round-robin: the requester not equal to last_grant wins.
  - last_grant updates on every grant.
  - A single requester is granted immediately regardless of last_grant.
- Requester contract: addr/we/wdata must be stable while reqN is high. reqN is dropped the cycle after gnt, or kept high to request again.
- Address is a word address with no wrap or bounds checking. Full ADDR_WIDTH is passed through.
- Reset asserted during ACCESS:
  - ram_wEn drops immediately and the in-flight write is lost.
  - A pending read produces no rvalid.
  - All state clears.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- When defined: fixed priority, requester 0 always wins contention. last_grant is not implemented, and requester 1 may starve.
- When undefined (default): round-robin as described above.

Test Plan:
- Single write then read, requester 0:
  - Stimulus: req0 write addr 4, data 0x00000001. Later, req0 read addr 4.
  - Response: gnt0 in T; ram_wEn = 1 only in T+1; read gives rvalid0 in T+2 with rdata0 = 0x00000001.
- Simultaneous contention:
  - Stimulus: req0 and req1 held high for 4 back-to-back reads.
  - Response: grants alternate 0, 1, 0, 1, each 2 cycles apart. With RAM_ARB_FIXED_PRIO_EN defined, all 4 grants go to 0.
- Loader preload then core read:
  - Stimulus: req1 writes 0xDEADBEEF, 0xBEEFDEAD, 0xBEDEADEF to addrs 200, 201, 202. Then req0 reads 200–202.
  - Response: rdata0 returns the same three values in order; rvalid1 never pulses.
- Isolation:
  - Stimulus: requester 1 read of addr 8 holding 0x00000002.
  - Response: rvalid1 pulses with rdata1 = 0x00000002; rvalid0 stays 0 and rdata0 is unchanged.
- Reset mid-write:
  - Stimulus: assert reset low during ACCESS of a write of 0x12345678 to addr 300, before the clock edge.
  - Response: ram_wEn = 0 immediately; outputs return to reset values; a subsequent read of addr 300 returns the old content.
- Idle:
  - Stimulus: no requests for 20 cycles.
  - Response: ram_wEn = 0, all gnt and rvalid low, state stays IDLE.
